// File: rtl/pipe_adder_nb_pkg.sv
// Shared definitions for the pipelined add/subtract unit: slice width default,
// add/sub mode encoding and the stage-count helper.
package pipe_adder_nb_pkg;

  localparam int SLICE_DEFAULT = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } add_mode_e;

  function automatic int num_stages(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/pipe_adder_nb_if.sv
// Operand/result streaming bus for pipe_adder_nb. The master drives operands
// and consumes results; the slave is the adder.
interface pipe_adder_nb_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipe_adder_nb_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB so
// the top slice can derive signed overflow.
module pipe_adder_slice
  import pipe_adder_nb_pkg::*;
#(
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    c    = cin;
    cmsb = 1'b0;
    s    = '0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) cmsb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder_nb.sv
// Pipelined WIDTH-bit add/subtract unit: one SLICE-bit ripple slice per stage,
// carry registered between stages, valid/ready streaming with full-pipe stall.
module pipe_adder_nb
  import pipe_adder_nb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  pipe_adder_nb_if.slave bus
);

  localparam int STAGES = num_stages(WIDTH, SLICE);

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  assign b_eff   = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign c_first = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

  // Stage k holds the finished low slices plus the operand slices still to add.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
    localparam int PW = (k + 1) * SLICE;
    localparam int RW = WIDTH - PW;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic [SLICE-1:0] s_slice;
    logic [RW-1:0]    up_a;
    logic [RW-1:0]    up_b;
    logic [PW-1:0]    s_next;
    logic             c_in;
    logic             v_in;
    logic             c_out;
    logic             cm_unused;

    logic [RW-1:0]    a_q;
    logic [RW-1:0]    b_q;
    logic [PW-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign op_a   = bus.a[SLICE-1:0];
      assign op_b   = b_eff[SLICE-1:0];
      assign up_a   = bus.a[WIDTH-1:SLICE];
      assign up_b   = b_eff[WIDTH-1:SLICE];
      assign c_in   = c_first;
      assign v_in   = bus.in_valid;
      assign s_next = s_slice;
    end else begin : g_src
      localparam int PRW = RW + SLICE;
      assign op_a   = g_st[k-1].a_q[SLICE-1:0];
      assign op_b   = g_st[k-1].b_q[SLICE-1:0];
      assign up_a   = g_st[k-1].a_q[PRW-1:SLICE];
      assign up_b   = g_st[k-1].b_q[PRW-1:SLICE];
      assign c_in   = g_st[k-1].c_q;
      assign v_in   = g_st[k-1].v_q;
      assign s_next = {s_slice, g_st[k-1].s_q};
    end

    pipe_adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (c_in),
      .s    (s_slice),
      .cout (c_out),
      .cmsb (cm_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        a_q <= up_a;
        b_q <= up_b;
        s_q <= s_next;
        c_q <= c_out;
        v_q <= v_in;
      end
    end
  end

  logic [SLICE-1:0] l_a;
  logic [SLICE-1:0] l_b;
  logic [SLICE-1:0] l_s;
  logic [WIDTH-1:0] l_sum;
  logic             l_c;
  logic             l_v;
  logic             l_cout;
  logic             l_cm;

  if (STAGES == 1) begin : g_last_src
    assign l_a   = bus.a;
    assign l_b   = b_eff;
    assign l_c   = c_first;
    assign l_v   = bus.in_valid;
    assign l_sum = l_s;
  end else begin : g_last_src
    assign l_a   = g_st[STAGES-2].a_q;
    assign l_b   = g_st[STAGES-2].b_q;
    assign l_c   = g_st[STAGES-2].c_q;
    assign l_v   = g_st[STAGES-2].v_q;
    assign l_sum = {l_s, g_st[STAGES-2].s_q};
  end

  pipe_adder_slice #(.SLICE(SLICE)) u_slice_last (
    .a    (l_a),
    .b    (l_b),
    .cin  (l_c),
    .s    (l_s),
    .cout (l_cout),
    .cmsb (l_cm)
  );

  // Result fields only load on a real beat so they hold while bubbles pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= l_v;
      if (l_v) begin
        sum_q  <= l_sum;
        cout_q <= l_cout;
        ovf_q  <= l_cm ^ l_cout;
      end
    end
  end

endmodule
